// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//  - arb_state_e : arbiter FSM state encoding
//  - DEF_TIMEOUT : default ack timeout in cycles
//  - DEF_ERR_DATA: read data substituted when an access times out
//  - to_cnt_w()  : width of the timeout counter for a given timeout
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // At least one bit so tiny timeouts still produce a legal vector.
    function automatic int unsigned to_cnt_w(input int unsigned t);
        return (t > 2) ? $clog2(t) : 1;
    endfunction

    localparam int unsigned TO_CNT_W = to_cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a memory acknowledge.
//  clk     in  rising-edge clock
//  rst_n   in  synchronous active-low reset
//  clr     in  restart the count (entry into a waiting state)
//  en      in  count this cycle (waiting, no ack)
//  expired out count has reached TIMEOUT-1; the owner aborts this cycle
module mem_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned     CW   = to_cnt_w(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// data stage (MEM) of the pipeline, runs each access as a ramReq/ramAck
// transaction, produces the pipeline stalls, drops fetches cancelled by a
// taken branch and aborts accesses whose acknowledge never arrives.
//  clk, rst_n                       clock, synchronous active-low reset
//  ifReq/ifAddr/ifFlush             fetch request, PC, branch cancel
//  ifRdata/ifValid                  fetched instruction + 1-cycle valid
//  memRdEn/memWrEn/memAddr/memWdata load/store request from MEM stage
//  memRdata/memValid                load data + 1-cycle completion
//  stallIF/stallPipe                pipeline freeze controls
//  ramReq/ramWe/ramAddr/ramWdata    registered memory request
//  ramRdata/ramAck                  memory response
//  busErr                           sticky timeout flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        TIMEOUT  = DEF_TIMEOUT,
    parameter logic [DATA_W-1:0]  ERR_DATA = DEF_ERR_DATA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    input  logic              ifFlush,
    output logic [DATA_W-1:0] ifRdata,
    output logic              ifValid,
    input  logic              memRdEn,
    input  logic              memWrEn,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memWdata,
    output logic [DATA_W-1:0] memRdata,
    output logic              memValid,
    output logic              stallIF,
    output logic              stallPipe,
    output logic              ramReq,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWdata,
    input  logic [DATA_W-1:0] ramRdata,
    input  logic              ramAck,
    output logic              busErr
);

    arb_state_e        state, state_d;
    logic              ram_req_d, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;
    logic              if_valid_d, mem_valid_d, bus_err_d;
    logic              to_clr, to_en, to_expired;

    // Restart on any entry into a waiting state, including FETCH -> DRAIN.
    assign to_clr = (state_d != IDLE) && (state_d != state);
    assign to_en  = (state != IDLE) && !ramAck;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_comb begin
        state_d     = state;
        ram_req_d   = ramReq;
        ram_we_d    = ramWe;
        ram_addr_d  = ramAddr;
        ram_wdata_d = ramWdata;
        if_rdata_d  = ifRdata;
        mem_rdata_d = memRdata;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        bus_err_d   = busErr;

        case (state)
            IDLE: begin
                // Requests are still held high during their own valid pulse;
                // masking them keeps that cycle from starting a second access.
                if ((memRdEn || memWrEn) && !memValid) begin
                    state_d     = DATA;
                    ram_req_d   = 1'b1;
                    ram_we_d    = memWrEn;
                    ram_addr_d  = memAddr;
                    ram_wdata_d = memWdata;
                end else if (ifReq && !ifFlush && !ifValid) begin
                    state_d    = FETCH;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = ifAddr;
                end
            end
            DATA: begin
                if (ramAck || to_expired) begin
                    state_d     = IDLE;
                    ram_req_d   = 1'b0;
                    mem_valid_d = 1'b1;
                    if (!ramAck) begin
                        bus_err_d = 1'b1;
                    end
                    if (!ramWe) begin
                        mem_rdata_d = ramAck ? ramRdata : ERR_DATA;
                    end
                end
            end
            FETCH: begin
                if (ramAck || to_expired) begin
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                    if (!ramAck) begin
                        bus_err_d = 1'b1;
                    end
                    if (!ifFlush) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = ramAck ? ramRdata : ERR_DATA;
                    end
                end else if (ifFlush) begin
                    // Memory still owes a response; keep the request up and
                    // swallow it in DRAIN.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ramAck || to_expired) begin
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                    if (!ramAck) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ramReq   <= 1'b0;
            ramWe    <= 1'b0;
            ramAddr  <= '0;
            ramWdata <= '0;
            ifRdata  <= '0;
            memRdata <= '0;
            ifValid  <= 1'b0;
            memValid <= 1'b0;
            busErr   <= 1'b0;
        end else begin
            state    <= state_d;
            ramReq   <= ram_req_d;
            ramWe    <= ram_we_d;
            ramAddr  <= ram_addr_d;
            ramWdata <= ram_wdata_d;
            ifRdata  <= if_rdata_d;
            memRdata <= mem_rdata_d;
            ifValid  <= if_valid_d;
            memValid <= mem_valid_d;
            busErr   <= bus_err_d;
        end
    end

    assign stallPipe = (memRdEn || memWrEn) && !memValid;
    assign stallIF   = stallPipe || (ifReq && !ifValid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data-over-fetch priority,
// store, flushed fetch with drain, timeout abort and reset mid-access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifReq, ifFlush, ifValid;
    logic [31:0] ifAddr, ifRdata;
    logic        memRdEn, memWrEn, memValid;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        stallIF, stallPipe;
    logic        ramReq, ramWe, ramAck, busErr;
    logic [31:0] ramAddr, ramWdata, ramRdata;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (16),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifReq     (ifReq),
        .ifAddr    (ifAddr),
        .ifFlush   (ifFlush),
        .ifRdata   (ifRdata),
        .ifValid   (ifValid),
        .memRdEn   (memRdEn),
        .memWrEn   (memWrEn),
        .memAddr   (memAddr),
        .memWdata  (memWdata),
        .memRdata  (memRdata),
        .memValid  (memValid),
        .stallIF   (stallIF),
        .stallPipe (stallPipe),
        .ramReq    (ramReq),
        .ramWe     (ramWe),
        .ramAddr   (ramAddr),
        .ramWdata  (ramWdata),
        .ramRdata  (ramRdata),
        .ramAck    (ramAck),
        .busErr    (busErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".ramReq"},   32'(ramReq),   32'h0);
        chk({tag, ".ramWe"},    32'(ramWe),    32'h0);
        chk({tag, ".ifValid"},  32'(ifValid),  32'h0);
        chk({tag, ".memValid"}, 32'(memValid), 32'h0);
        chk({tag, ".busErr"},   32'(busErr),   32'h0);
        chk({tag, ".ramAddr"},  ramAddr,       32'h0);
        chk({tag, ".ramWdata"}, ramWdata,      32'h0);
        chk({tag, ".ifRdata"},  ifRdata,       32'h0);
        chk({tag, ".memRdata"}, memRdata,      32'h0);
    endtask

    initial begin
        rst_n = 1'b0; ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
        memRdEn = 1'b0; memWrEn = 1'b0; memAddr = '0; memWdata = '0;
        ramAck = 1'b0; ramRdata = '0;
        tick();
        tick();
        chk_reset_state("reset");
        chk("reset.stallIF",   32'(stallIF),   32'h0);
        chk("reset.stallPipe", 32'(stallPipe), 32'h0);
        rst_n = 1'b1;

        // 1: plain fetch, ack two cycles after ramReq rises
        ifReq = 1'b1; ifAddr = 32'h100;
        #1 chk("t1.stallIF_req", 32'(stallIF), 32'h1);
        tick();
        chk("t1.ramReq",  32'(ramReq), 32'h1);
        chk("t1.ramWe",   32'(ramWe),  32'h0);
        chk("t1.ramAddr", ramAddr,     32'h100);
        tick();
        chk("t1.stallIF_wait", 32'(stallIF), 32'h1);
        chk("t1.noValid",      32'(ifValid), 32'h0);
        ramAck = 1'b1; ramRdata = 32'h1111_1111;
        tick();
        ramAck = 1'b0;
        chk("t1.ifValid",    32'(ifValid), 32'h1);
        chk("t1.ifRdata",    ifRdata,      32'h1111_1111);
        chk("t1.ramReqDrop", 32'(ramReq),  32'h0);
        chk("t1.stallIF_done", 32'(stallIF), 32'h0);
        ifReq = 1'b0;
        tick();
        chk("t1.pulse", 32'(ifValid), 32'h0);

        // 2: simultaneous fetch and load, load goes first
        ifReq = 1'b1; ifAddr = 32'h200; memRdEn = 1'b1; memAddr = 32'h300;
        #1 chk("t2.stallPipe", 32'(stallPipe), 32'h1);
        tick();
        chk("t2.ramReq",  32'(ramReq), 32'h1);
        chk("t2.ramWe",   32'(ramWe),  32'h0);
        chk("t2.ramAddr", ramAddr,     32'h300);
        ramAck = 1'b1; ramRdata = 32'h2222_2222;
        tick();
        ramAck = 1'b0;
        chk("t2.memValid",  32'(memValid),  32'h1);
        chk("t2.memRdata",  memRdata,       32'h2222_2222);
        chk("t2.ramReqLow", 32'(ramReq),    32'h0);
        chk("t2.stallPipe0", 32'(stallPipe), 32'h0);
        chk("t2.stallIF1",  32'(stallIF),   32'h1);
        memRdEn = 1'b0;
        tick();
        chk("t2.fetchReq",  32'(ramReq),   32'h1);
        chk("t2.fetchAddr", ramAddr,       32'h200);
        chk("t2.memPulse",  32'(memValid), 32'h0);
        ramAck = 1'b1; ramRdata = 32'h3333_3333;
        tick();
        ramAck = 1'b0;
        chk("t2.ifValid", 32'(ifValid), 32'h1);
        chk("t2.ifRdata", ifRdata,      32'h3333_3333);
        ifReq = 1'b0;
        tick();

        // 3: store, load data register must not move
        memWrEn = 1'b1; memAddr = 32'h40; memWdata = 32'h0000_00AB;
        tick();
        chk("t3.ramReq",   32'(ramReq), 32'h1);
        chk("t3.ramWe",    32'(ramWe),  32'h1);
        chk("t3.ramAddr",  ramAddr,     32'h40);
        chk("t3.ramWdata", ramWdata,    32'h0000_00AB);
        ramAck = 1'b1; ramRdata = 32'h5555_5555;
        tick();
        ramAck = 1'b0;
        chk("t3.memValid", 32'(memValid), 32'h1);
        chk("t3.memRdata", memRdata,      32'h2222_2222);
        memWrEn = 1'b0;
        tick();
        chk("t3.pulse",  32'(memValid), 32'h0);
        chk("t3.reqLow", 32'(ramReq),   32'h0);

        // 4: fetch flushed one cycle in, drained, then refetch at new PC
        ifReq = 1'b1; ifAddr = 32'h500;
        tick();
        chk("t4.ramAddr", ramAddr, 32'h500);
        ifFlush = 1'b1; ifAddr = 32'h600;
        tick();
        ifFlush = 1'b0;
        chk("t4.drainReq",  32'(ramReq),  32'h1);
        chk("t4.addrHold",  ramAddr,      32'h500);
        chk("t4.noValid0",  32'(ifValid), 32'h0);
        tick();
        tick();
        chk("t4.drainReq2", 32'(ramReq), 32'h1);
        ramAck = 1'b1; ramRdata = 32'h6666_6666;
        tick();
        ramAck = 1'b0;
        chk("t4.noValid1", 32'(ifValid), 32'h0);
        chk("t4.reqLow",   32'(ramReq),  32'h0);
        tick();
        chk("t4.refetchReq",  32'(ramReq), 32'h1);
        chk("t4.refetchAddr", ramAddr,     32'h600);
        ramAck = 1'b1; ramRdata = 32'h7777_7777;
        tick();
        ramAck = 1'b0;
        chk("t4.ifValid", 32'(ifValid), 32'h1);
        chk("t4.ifRdata", ifRdata,      32'h7777_7777);
        ifReq = 1'b0;
        tick();

        // 5: load never acked -> abort after 16 waiting cycles
        memRdEn = 1'b1; memAddr = 32'h80;
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("t5.waitReq", 32'(ramReq), 32'h1);
            chk("t5.noErr",   32'(busErr), 32'h0);
            tick();
        end
        chk("t5.lastWaitReq", 32'(ramReq), 32'h1);
        tick();
        chk("t5.busErr",   32'(busErr),   32'h1);
        chk("t5.memValid", 32'(memValid), 32'h1);
        chk("t5.memRdata", memRdata,      32'hDEAD_BEEF);
        chk("t5.reqDrop",  32'(ramReq),   32'h0);
        memRdEn = 1'b0;
        tick();
        tick();
        chk("t5.sticky", 32'(busErr),   32'h1);
        chk("t5.pulse",  32'(memValid), 32'h0);

        // 6: reset in the middle of a load, then a stray ack
        memRdEn = 1'b1; memAddr = 32'hC0;
        tick();
        chk("t6.ramReq", 32'(ramReq), 32'h1);
        rst_n = 1'b0; memRdEn = 1'b0;
        tick();
        rst_n = 1'b1; ramAck = 1'b1; ramRdata = 32'h9999_9999;
        tick();
        ramAck = 1'b0;
        chk_reset_state("t6");
        tick();
        chk_reset_state("t6b");
        chk("t6.stallPipe", 32'(stallPipe), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
